race_controller: RTL and testbench

RACE_CONTROLLER -- requirements
Module: race_controller

---
 rtl/race_controller.sv | 172 +++++++++++++++++
 tb/tb_race_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// Race sequencer: start countdown, lap timing in centiseconds, lap validation and scoring.
// A free tick counter paces time; lap events are rising edges of lap_finished.
module race_controller #(
  parameter int unsigned CLK_HZ  = 65000000,
  parameter int unsigned LAPS    = 3,
  parameter int unsigned COUNT_S = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        lap_finished,
  input  logic        checkpoints_passed,
  output logic [1:0]  race_state,
  output logic [1:0]  countdown,
  output logic        car_enable,
  output logic [2:0]  lap_count,
  output logic [13:0] lap_time_cs,
  output logic [13:0] best_lap_cs,
  output logic        lap_valid,
  output logic        race_done
);

  localparam int unsigned TICK_DIV     = (CLK_HZ / 100 > 0) ? CLK_HZ / 100 : 1;
  localparam int unsigned TW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [13:0] LAP_TIME_MAX = 14'd9999;
  localparam logic [13:0] NO_LAP       = 14'h3FFF;
  localparam logic [2:0]  LAPS_L       = 3'(LAPS);
  localparam logic [1:0]  COUNT_L      = 2'(COUNT_S);
  localparam logic [6:0]  CS_PER_S     = 7'd99;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_RACING    = 2'b10,
    ST_FINISHED  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [6:0]    cs_cnt_q, cs_cnt_d;
  logic [1:0]    countdown_q, countdown_d;
  logic [2:0]    lap_count_q, lap_count_d;
  logic [13:0]   lap_time_q, lap_time_d;
  logic [13:0]   best_q, best_d;
  logic          lap_valid_q, lap_valid_d;
  logic          lf_prev_q, lf_prev_d;
  logic          start_low_q, start_low_d;

  logic          tick;
  logic          lap_event;
  logic [2:0]    laps_next;
  logic [13:0]   best_min;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign lap_event = lap_finished & ~lf_prev_q & checkpoints_passed;
  assign laps_next = lap_count_q + 3'd1;
  assign best_min  = (lap_time_q < best_q) ? lap_time_q : best_q;

  always_comb begin
    state_d     = state_q;
    cs_cnt_d    = cs_cnt_q;
    countdown_d = countdown_q;
    lap_count_d = lap_count_q;
    lap_time_d  = lap_time_q;
    best_d      = best_q;
    lap_valid_d = 1'b0;
    lf_prev_d   = lap_finished;
    start_low_d = start_low_q;
    tick_cnt_d  = tick_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = COUNT_L;
          cs_cnt_d    = 7'd0;
          lap_count_d = 3'd0;
          best_d      = NO_LAP;
          lap_time_d  = 14'd0;
        end
      end

      ST_COUNTDOWN: begin
        if (tick) begin
          if (cs_cnt_q == CS_PER_S) begin
            cs_cnt_d = 7'd0;
            // Leave on the tick that would otherwise show zero.
            if (countdown_q == 2'd1) begin
              state_d     = ST_RACING;
              countdown_d = 2'd0;
              lap_time_d  = 14'd0;
              lap_count_d = 3'd0;
            end else begin
              countdown_d = countdown_q - 2'd1;
            end
          end else begin
            cs_cnt_d = cs_cnt_q + 7'd1;
          end
        end
      end

      ST_RACING: begin
        if (lap_event) begin
          // Scoring uses the time before any coincident tick; the clear wins.
          lap_valid_d = 1'b1;
          lap_count_d = laps_next;
          best_d      = best_min;
          lap_time_d  = 14'd0;
          if (laps_next == LAPS_L) begin
            state_d     = ST_FINISHED;
            start_low_d = 1'b0;
          end
        end else if (tick && (lap_time_q != LAP_TIME_MAX)) begin
          lap_time_d = lap_time_q + 14'd1;
        end
      end

      ST_FINISHED: begin
        if (!start) begin
          start_low_d = 1'b1;
        end else if (start_low_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if ((state_d != state_q) || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      cs_cnt_q    <= 7'd0;
      countdown_q <= 2'd0;
      lap_count_q <= 3'd0;
      lap_time_q  <= 14'd0;
      best_q      <= NO_LAP;
      lap_valid_q <= 1'b0;
      lf_prev_q   <= 1'b1;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      cs_cnt_q    <= cs_cnt_d;
      countdown_q <= countdown_d;
      lap_count_q <= lap_count_d;
      lap_time_q  <= lap_time_d;
      best_q      <= best_d;
      lap_valid_q <= lap_valid_d;
      lf_prev_q   <= lf_prev_d;
      start_low_q <= start_low_d;
    end
  end

  assign race_state  = state_q;
  assign countdown   = countdown_q;
  assign car_enable  = (state_q == ST_RACING);
  assign lap_count   = lap_count_q;
  assign lap_time_cs = lap_time_q;
  assign best_lap_cs = best_q;
  assign lap_valid   = lap_valid_q;
  assign race_done   = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: directed segment table, randomized race traffic against a
// time-based reference model, and a fast-tick instance for lap-time saturation.
module tb_race_controller;

  localparam int CLK_HZ  = 1000;
  localparam int LAPS    = 2;
  localparam int COUNT_S = 3;
  localparam int TICK    = CLK_HZ / 100;
  localparam int SEC     = 100 * TICK;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst, start, lap_finished, checkpoints_passed;
  logic [1:0]  race_state, countdown;
  logic        car_enable, lap_valid, race_done;
  logic [2:0]  lap_count;
  logic [13:0] lap_time_cs, best_lap_cs;

  logic        s_rst, s_start, s_lf, s_cp;
  logic [1:0]  s_state, s_cd;
  logic        s_car, s_lv, s_done;
  logic [2:0]  s_laps;
  logic [13:0] s_lt, s_best;

  race_controller #(.CLK_HZ(CLK_HZ), .LAPS(LAPS), .COUNT_S(COUNT_S)) dut (
    .pclk(pclk), .rst(rst), .start(start), .lap_finished(lap_finished),
    .checkpoints_passed(checkpoints_passed), .race_state(race_state), .countdown(countdown),
    .car_enable(car_enable), .lap_count(lap_count), .lap_time_cs(lap_time_cs),
    .best_lap_cs(best_lap_cs), .lap_valid(lap_valid), .race_done(race_done));

  // One tick per cycle so saturation is reachable quickly.
  race_controller #(.CLK_HZ(100), .LAPS(2), .COUNT_S(1)) dut_s (
    .pclk(pclk), .rst(s_rst), .start(s_start), .lap_finished(s_lf),
    .checkpoints_passed(s_cp), .race_state(s_state), .countdown(s_cd),
    .car_enable(s_car), .lap_count(s_laps), .lap_time_cs(s_lt),
    .best_lap_cs(s_best), .lap_valid(s_lv), .race_done(s_done));

  int checks = 0;
  int failures = 0;
  int row_pulses = 0;

  // Reference model: phase 0..3 and edge timestamps; outputs derived arithmetically.
  int m_phase = 0, m_e = 0, m_cd_start = 0, m_rs = 0, m_last = 0, m_laps = 0, m_best = 16383;
  bit m_lfp = 1'b1, m_start_low = 1'b0, m_lv = 1'b0;

  function automatic int m_lap_time(int e);
    int t;
    if (m_phase != 2) return 0;
    t = (e - m_rs) / TICK - (m_last - m_rs) / TICK;
    return (t > 9999) ? 9999 : t;
  endfunction

  function automatic int m_countdown(int e);
    return (m_phase == 1) ? COUNT_S - (e - m_cd_start) / SEC : 0;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit lf, input bit cp);
    int lt_pre;
    bit ev;
    lt_pre = m_lap_time(m_e);
    ev = lf && !m_lfp;
    m_e++;
    if (r) begin
      m_phase = 0; m_laps = 0; m_best = 16383; m_lfp = 1'b1; m_lv = 1'b0; m_start_low = 1'b0;
    end else begin
      m_lv = 1'b0;
      case (m_phase)
        0: if (s) begin m_phase = 1; m_cd_start = m_e; m_laps = 0; m_best = 16383; end
        1: if (m_e - m_cd_start == COUNT_S * SEC) begin
             m_phase = 2; m_rs = m_e; m_last = m_e; m_laps = 0;
           end
        2: if (ev && cp) begin
             m_lv = 1'b1; m_laps++;
             if (lt_pre < m_best) m_best = lt_pre;
             m_last = m_e;
             if (m_laps == LAPS) begin m_phase = 3; m_start_low = 1'b0; end
           end
        default: if (!s) m_start_low = 1'b1;
                 else if (m_start_low) m_phase = 0;
      endcase
      m_lfp = lf;
    end
  endtask

  task automatic check_model();
    logic [36:0] exp_v, act_v;
    exp_v = {2'(m_phase), 2'(m_countdown(m_e)), (m_phase == 2), 3'(m_laps),
             14'(m_lap_time(m_e)), 14'(m_best), m_lv, (m_phase == 3)};
    act_v = {race_state, countdown, car_enable, lap_count, lap_time_cs, best_lap_cs,
             lap_valid, race_done};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model edge=%0d got=%h expected=%h", m_e, act_v, exp_v);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit lf, input bit cp);
    @(negedge pclk);
    rst = r; start = s; lap_finished = lf; checkpoints_passed = cp;
    @(posedge pclk);
    #1;
    model_edge(r, s, lf, cp);
    check_model();
    if (lap_valid) row_pulses++;
  endtask

  typedef struct {
    bit r, s, lf, cp;
    int n;
    int st, cd, laps, lt, best, pulses;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit lf, bit cp, int n, int st, int cd,
                              int laps, int lt, int best, int pulses);
    vec_t v;
    v.r = r; v.s = s; v.lf = lf; v.cp = cp; v.n = n;
    v.st = st; v.cd = cd; v.laps = laps; v.lt = lt; v.best = best; v.pulses = pulses;
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; lap_finished = 1'b0; checkpoints_passed = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_lf = 1'b0; s_cp = 1'b0;

    // r s lf cp  cycles  state cd laps lap_time best pulses
    tbl[0]  = mk(1, 0, 0, 0,    2, 0, 0, 0,   0, 16383, 0);
    tbl[1]  = mk(0, 1, 0, 0,    1, 1, 3, 0,   0, 16383, 0);
    tbl[2]  = mk(0, 0, 0, 0,  999, 1, 3, 0,   0, 16383, 0);
    tbl[3]  = mk(0, 0, 0, 0,    1, 1, 2, 0,   0, 16383, 0);
    tbl[4]  = mk(0, 1, 0, 0,  999, 1, 2, 0,   0, 16383, 0);
    tbl[5]  = mk(0, 0, 0, 0,    1, 1, 1, 0,   0, 16383, 0);
    tbl[6]  = mk(0, 0, 0, 0,  999, 1, 1, 0,   0, 16383, 0);
    tbl[7]  = mk(0, 0, 0, 0,    1, 2, 0, 0,   0, 16383, 0);
    tbl[8]  = mk(0, 0, 0, 0,  100, 2, 0, 0,  10, 16383, 0);
    tbl[9]  = mk(0, 0, 1, 0,   20, 2, 0, 0,  12, 16383, 0);
    tbl[10] = mk(0, 0, 0, 0, 5110, 2, 0, 0, 523, 16383, 0);
    tbl[11] = mk(0, 0, 1, 1,   50, 2, 0, 1,   5,   523, 1);
    tbl[12] = mk(0, 1, 0, 0, 6050, 2, 0, 1, 610,   523, 0);
    tbl[13] = mk(0, 0, 1, 1,    1, 3, 0, 2,   0,   523, 1);
    tbl[14] = mk(0, 1, 1, 1,    3, 3, 0, 2,   0,   523, 0);
    tbl[15] = mk(0, 0, 0, 0,    1, 3, 0, 2,   0,   523, 0);
    tbl[16] = mk(0, 1, 0, 0,    1, 0, 0, 2,   0,   523, 0);
    tbl[17] = mk(0, 0, 0, 0,    5, 0, 0, 2,   0,   523, 0);
    tbl[18] = mk(0, 1, 0, 0,    1, 1, 3, 0,   0, 16383, 0);
    tbl[19] = mk(0, 0, 0, 0, 3000, 2, 0, 0,   0, 16383, 0);
    tbl[20] = mk(0, 0, 0, 0,  300, 2, 0, 0,  30, 16383, 0);
    tbl[21] = mk(0, 0, 1, 1,    1, 2, 0, 1,   0,    30, 1);
    tbl[22] = mk(0, 0, 1, 1,    5, 2, 0, 1,   0,    30, 0);
    tbl[23] = mk(1, 0, 1, 1,    1, 0, 0, 0,   0, 16383, 0);
    tbl[24] = mk(0, 0, 1, 1,    3, 0, 0, 0,   0, 16383, 0);

    @(posedge pclk);
    #1;
    checks++;
    if ({s_state, s_cd, s_car, s_laps, s_lt, s_best, s_lv, s_done} !==
        {2'b00, 2'b00, 1'b0, 3'd0, 14'd0, 14'h3FFF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fast_reset got st=%0d cd=%0d laps=%0d lt=%0d best=%h lv=%0b done=%0b car=%0b",
               s_state, s_cd, s_laps, s_lt, s_best, s_lv, s_done, s_car);
    end

    for (int i = 0; i < 25; i++) begin
      row_pulses = 0;
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].r, tbl[i].s, tbl[i].lf, tbl[i].cp);
      checks++;
      if (race_state !== 2'(tbl[i].st) || countdown !== 2'(tbl[i].cd) ||
          car_enable !== (tbl[i].st == 2) || race_done !== (tbl[i].st == 3) ||
          lap_count !== 3'(tbl[i].laps) || lap_time_cs !== 14'(tbl[i].lt) ||
          best_lap_cs !== 14'(tbl[i].best) || row_pulses != tbl[i].pulses) begin
        failures++;
        $display("FAIL row%0d got st=%0d cd=%0d car=%0b done=%0b laps=%0d lt=%0d best=%0d pulses=%0d required st=%0d cd=%0d laps=%0d lt=%0d best=%0d pulses=%0d",
                 i, race_state, countdown, car_enable, race_done, lap_count, lap_time_cs,
                 best_lap_cs, row_pulses, tbl[i].st, tbl[i].cd, tbl[i].laps, tbl[i].lt,
                 tbl[i].best, tbl[i].pulses);
      end
    end

    begin
      int cyc;
      cyc = 0;
      while (cyc < 15000) begin
        bit r, s, lf, cp;
        int len;
        r   = ($urandom_range(0, 59) == 0);
        s   = ($urandom_range(0, 3) == 0);
        lf  = $urandom_range(0, 1);
        cp  = $urandom_range(0, 1);
        len = r ? 1 : $urandom_range(1, 300);
        for (int c = 0; c < len; c++) step(r, s, lf, cp);
        cyc += len;
      end
    end

    @(negedge pclk);
    s_rst = 1'b0; s_start = 1'b1;
    @(negedge pclk);
    s_start = 1'b0;
    k = 0;
    while (s_state !== 2'b10 && k < 300) begin
      @(posedge pclk);
      #1;
      k++;
    end
    checks++;
    if (k != 100) begin
      failures++;
      $display("FAIL fast_countdown_len got=%0d required=100", k);
    end
    repeat (9998) @(posedge pclk);
    #1;
    checks++;
    if (s_lt !== 14'd9998) begin
      failures++;
      $display("FAIL fast_lt_9998 got=%0d required=9998", s_lt);
    end
    @(posedge pclk);
    #1;
    checks++;
    if (s_lt !== 14'd9999) begin
      failures++;
      $display("FAIL fast_lt_9999 got=%0d required=9999", s_lt);
    end
    repeat (50) @(posedge pclk);
    #1;
    checks++;
    if (s_lt !== 14'd9999 || s_state !== 2'b10 || s_car !== 1'b1 || s_laps !== 3'd0) begin
      failures++;
      $display("FAIL fast_saturate got lt=%0d st=%0d car=%0b laps=%0d required lt=9999 st=2 car=1 laps=0",
               s_lt, s_state, s_car, s_laps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
